// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store controller:
// RISC-V funct3 size codes and the controller FSM state type.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWrite,
        StResp
    } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_ctrl_if.sv
// Request/response handshake plus the word-wide data-memory port.
// The slave side is the controller; the master side is core + memory.
interface dmem_lsu_ctrl_if #(
    parameter int unsigned ADDR_W = 9
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane logic: load extract/extend and sub-word store merge.
module lsu_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [15:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];

        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata = {24'h0, byte_sel};
            F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata = {16'h0, half_sel};
            F3_W:    rdata = word;
            default: rdata = '0;
        endcase

        merged = word;
        case (funct3)
            F3_B: merged[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (lane[1]) merged[31:16] = wdata;
                else         merged[15:0]  = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Single-outstanding load/store sequencer for a 512x32 single-port data memory.
// Sub-word stores are read-modify-write; all outputs are registered.
module dmem_lsu_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input logic            clk,
    input logic            rst,
    dmem_lsu_ctrl_if.slave bus
);

    lsu_state_e  state;
    logic        op_we;
    logic [2:0]  op_f3;
    logic [1:0]  op_lane;
    logic [15:0] op_wdata;

    logic        f3_bad;
    logic        misal;
    logic        oor;
    logic        req_err;
    logic [31:0] lane_rdata;
    logic [31:0] lane_merged;

    always_comb begin
        f3_bad = 1'b1;
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: f3_bad = 1'b0;
            F3_BU, F3_HU:     f3_bad = bus.req_we;
            default:          f3_bad = 1'b1;
        endcase
        misal = ((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU) && bus.req_addr[0])
              || (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00);
        oor     = |(bus.req_addr >> (ADDR_W + 2));
        req_err = f3_bad | misal | oor;
    end

    lsu_lane_align u_lane (
        .word   (bus.mem_rdata),
        .lane   (op_lane),
        .funct3 (op_f3),
        .wdata  (op_wdata),
        .rdata  (lane_rdata),
        .merged (lane_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            op_we          <= 1'b0;
            op_f3          <= '0;
            op_lane        <= '0;
            op_wdata       <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_we     <= 1'b0;
            bus.mem_wdata  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.req_valid) begin
                        op_we         <= bus.req_we;
                        op_f3         <= bus.req_funct3;
                        op_lane       <= bus.req_addr[1:0];
                        op_wdata      <= bus.req_wdata[15:0];
                        bus.req_ready <= 1'b0;
                        if (req_err) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            state          <= StResp;
                        end else begin
                            bus.mem_addr <= bus.req_addr[ADDR_W+1:2];
                            // Full-word stores write straight out of ACCESS.
                            if (bus.req_we && bus.req_funct3 == F3_W) begin
                                bus.mem_we    <= 1'b1;
                                bus.mem_wdata <= bus.req_wdata;
                            end
                            state <= StAccess;
                        end
                    end
                end
                StAccess: begin
                    bus.mem_we    <= 1'b0;
                    bus.mem_wdata <= '0;
                    if (!op_we) begin
                        bus.resp_rdata <= lane_rdata;
                        bus.resp_valid <= 1'b1;
                        state          <= StResp;
                    end else if (op_f3 == F3_W) begin
                        bus.resp_valid <= 1'b1;
                        state          <= StResp;
                    end else begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_wdata <= lane_merged;
                        state         <= StWrite;
                    end
                end
                StWrite: begin
                    bus.mem_we     <= 1'b0;
                    bus.mem_wdata  <= '0;
                    bus.resp_valid <= 1'b1;
                    state          <= StResp;
                end
                StResp: begin
                    bus.resp_valid <= 1'b0;
                    bus.resp_rdata <= '0;
                    bus.resp_err   <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl with a behavioural 512x32 data memory.
module tb_dmem_lsu_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_mem = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [31:0] mem [512];

    dmem_lsu_ctrl_if #(.ADDR_W(9)) bus ();

    dmem_lsu_ctrl #(.ADDR_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 512; i++) mem[i] <= '0;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
    endtask

    // One request; watches four cycles after acceptance for response and write timing.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int lat,
                          input logic [31:0] exp_rd, input logic exp_err, input int we_cyc,
                          input logic [31:0] exp_ma);
        int resp_cnt;
        int we_cnt;
        resp_cnt = 0;
        we_cnt   = 0;
        @(negedge clk);
        check({tag, ".ready"}, bus.req_ready, 1);
        drive(we, f3, addr, wd);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                resp_cnt++;
                check({tag, ".resp_cyc"}, k, lat);
                check({tag, ".rdata"}, bus.resp_rdata, exp_rd);
                check({tag, ".err"}, bus.resp_err, exp_err);
            end else begin
                check({tag, ".rdata_idle"}, bus.resp_rdata, 0);
            end
            if (bus.mem_we) begin
                we_cnt++;
                check({tag, ".we_cyc"}, k, we_cyc);
                check({tag, ".mem_addr"}, bus.mem_addr, exp_ma);
            end else begin
                check({tag, ".wdata_gate"}, bus.mem_wdata, 0);
            end
        end
        check({tag, ".resp_cnt"}, resp_cnt, 1);
        check({tag, ".we_cnt"}, we_cnt, (we_cyc != 0) ? 1 : 0);
    endtask

    initial begin
        int resp_cnt;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_mem = 1'b0;
        check("rst.ready", bus.req_ready, 1);
        check("rst.resp_valid", bus.resp_valid, 0);
        check("rst.rdata", bus.resp_rdata, 0);
        check("rst.err", bus.resp_err, 0);
        check("rst.mem_we", bus.mem_we, 0);
        check("rst.mem_addr", bus.mem_addr, 0);
        check("rst.mem_wdata", bus.mem_wdata, 0);
        rst = 1'b0;

        do_req("sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 0, 0, 1, 4);
        check("sw10.mem", mem[4], 32'hDEADBEEF);
        do_req("lw10", 0, 3'b010, 32'h10, 0, 2, 32'hDEADBEEF, 0, 0, 0);

        do_req("sb13", 1, 3'b000, 32'h13, 32'h000000AA, 3, 0, 0, 2, 4);
        check("sb13.mem", mem[4], 32'hAAADBEEF);
        do_req("lb13", 0, 3'b000, 32'h13, 0, 2, 32'hFFFFFFAA, 0, 0, 0);
        do_req("lbu13", 0, 3'b100, 32'h13, 0, 2, 32'h000000AA, 0, 0, 0);
        do_req("lbu11", 0, 3'b100, 32'h11, 0, 2, 32'h000000BE, 0, 0, 0);

        do_req("sh12", 1, 3'b001, 32'h12, 32'h00001234, 3, 0, 0, 2, 4);
        check("sh12.mem", mem[4], 32'h1234BEEF);
        do_req("lhu10", 0, 3'b101, 32'h10, 0, 2, 32'h0000BEEF, 0, 0, 0);
        do_req("lh10", 0, 3'b001, 32'h10, 0, 2, 32'hFFFFBEEF, 0, 0, 0);
        do_req("lh12", 0, 3'b001, 32'h12, 0, 2, 32'h00001234, 0, 0, 0);

        do_req("err_lw11", 0, 3'b010, 32'h11, 0, 1, 0, 1, 0, 0);
        do_req("err_sh13", 1, 3'b001, 32'h13, 32'hFFFF, 1, 0, 1, 0, 0);
        do_req("err_lw800", 0, 3'b010, 32'h800, 0, 1, 0, 1, 0, 0);
        do_req("err_f3_011", 0, 3'b011, 32'h10, 0, 1, 0, 1, 0, 0);
        do_req("err_st_f3_100", 1, 3'b100, 32'h10, 32'h77, 1, 0, 1, 0, 0);
        check("err.mem", mem[4], 32'h1234BEEF);
        check("err.mem0", mem[0], 32'h0);

        // Busy: request held and changed while the controller is mid-operation.
        resp_cnt = 0;
        @(negedge clk);
        drive(0, 3'b010, 32'h10, 0);
        @(negedge clk);
        check("busy.k1.ready", bus.req_ready, 0);
        drive(0, 3'b101, 32'h12, 0);
        @(negedge clk);
        check("busy.k2.ready", bus.req_ready, 0);
        check("busy.k2.resp_valid", bus.resp_valid, 1);
        check("busy.k2.rdata", bus.resp_rdata, 32'h1234BEEF);
        drive(0, 3'b101, 32'h10, 0);
        @(negedge clk);
        check("busy.k3.ready", bus.req_ready, 1);
        check("busy.k3.resp_valid", bus.resp_valid, 0);
        drive(0, 3'b000, 32'h13, 0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                resp_cnt++;
                check("busy.resp_cyc", k, 5);
                check("busy.rdata2", bus.resp_rdata, 32'h00000012);
            end
        end
        check("busy.resp_cnt", resp_cnt, 1);

        // Reset during the WRITE cycle of an RMW byte store.
        @(negedge clk);
        drive(1, 3'b000, 32'h10, 32'h55);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("rmw.we_before_rst", bus.mem_we, 1);
        rst = 1'b1;
        #1;
        check("rmw.mem_we", bus.mem_we, 0);
        check("rmw.mem_wdata", bus.mem_wdata, 0);
        check("rmw.mem_addr", bus.mem_addr, 0);
        check("rmw.ready", bus.req_ready, 1);
        check("rmw.resp_valid", bus.resp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        resp_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.resp_valid) resp_cnt++;
        end
        check("rmw.no_resp", resp_cnt, 0);
        check("rmw.mem", mem[4], 32'h1234BEEF);
        do_req("rmw.lw10", 0, 3'b010, 32'h10, 0, 2, 32'h1234BEEF, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
